// File: rtl/i2s_tdm_tx.sv
// Slave-mode TDM/I2S transmitter: CHANNELS slots of SLOT bits, each carrying a
// BITSIZE-bit sample MSB-first. One multi-channel word per frame is accepted
// through a valid/ready handshake into a one-deep holding register.
// All state advances on the falling edge of sclk.
module i2s_tdm_tx #(
   parameter int unsigned BITSIZE         = 16,
   parameter int unsigned SLOT            = 32,
   parameter int unsigned CHANNELS        = 2,
   parameter int unsigned DELAY           = 1,
   parameter int unsigned UNDERRUN_REPEAT = 0
) (
   input  logic                         sclk,
   input  logic                         rst,
   input  logic                         lrclk,
   input  logic [CHANNELS*BITSIZE-1:0]  in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic                         sdata,
   output logic                         frame_start,
   output logic                         underrun,
   output logic                         sync_err
);

   localparam int unsigned FrameBits = CHANNELS * SLOT;
   localparam int unsigned SampW     = CHANNELS * BITSIZE;
   localparam int unsigned CntW      = $clog2(FrameBits) + 1;

   localparam logic [CntW-1:0] CntMax  = CntW'(FrameBits);
   localparam logic [CntW-1:0] CntLast = CntW'(FrameBits - 1);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   // Slot 0 occupies the top of the image so the buffer shifts out MSB-first.
   function automatic logic [FrameBits-1:0] build_image(input logic [SampW-1:0] s);
      logic [FrameBits-1:0] img;
      img = '0;
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
         img[FrameBits-1-ch*SLOT -: BITSIZE] = s[ch*BITSIZE +: BITSIZE];
      end
      return img;
   endfunction

   logic                 lr_q;
   logic [SampW-1:0]     hold_q, hold_d;
   logic                 hold_full_q, hold_full_d;
   logic [SampW-1:0]     last_q, last_d;
   logic [FrameBits-1:0] buf_q, buf_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 sdata_q, sdata_d;
   logic                 frame_start_q, underrun_q, sync_err_q;

   logic                 det, xfer, under, short_frame, raw;
   logic [SampW-1:0]     src;
   logic [FrameBits-1:0] img;

   assign det         = lr_q & ~lrclk;
   assign xfer        = in_valid & ~hold_full_q;
   assign short_frame = det & (cnt_q < CntLast);

   // Source selection at frame start, holding-register fill, and the shift buffer.
   always_comb begin
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      last_d      = last_q;
      src         = '0;
      under       = 1'b0;
      if (det) begin
         if (hold_full_q) begin
            src         = hold_q;
            hold_full_d = 1'b0;
            last_d      = hold_q;
         end else if (xfer) begin
            // Bypass: the word goes straight into the frame, hold stays empty.
            src    = in_data;
            last_d = in_data;
         end else begin
            under = 1'b1;
            src   = (UNDERRUN_REPEAT != 0) ? last_q : '0;
         end
      end else if (xfer) begin
         hold_d      = in_data;
         hold_full_d = 1'b1;
      end
      img = build_image(src);
      if (det) begin
         // Restart drops whatever is left of the old frame.
         raw   = img[FrameBits-1];
         buf_d = img << 1;
         cnt_d = '0;
      end else begin
         // Buffer fills with zeros, so bits past the frame end are 0.
         raw   = buf_q[FrameBits-1];
         buf_d = buf_q << 1;
         cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
      end
   end

   // Data delay between the frame bit stream and the sdata pin.
   if (DELAY == 0) begin : g_nodly
      assign sdata_d = raw;
   end else begin : g_dly
      logic [DELAY-1:0] pipe_q, pipe_d;

      // Next-state of the delay line: shift in the current frame bit.
      always_comb begin
         pipe_d    = pipe_q << 1;
         pipe_d[0] = raw;
      end

      // Delay line register.
      always_ff @(negedge sclk or negedge rst) begin
         if (!rst) pipe_q <= '0;
         else      pipe_q <= pipe_d;
      end

      assign sdata_d = pipe_q[DELAY-1];
   end

   // State and registered outputs.
   always_ff @(negedge sclk or negedge rst) begin
      if (!rst) begin
         lr_q          <= 1'b1;
         hold_q        <= '0;
         hold_full_q   <= 1'b0;
         last_q        <= '0;
         buf_q         <= '0;
         cnt_q         <= CntMax;
         sdata_q       <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         lr_q          <= lrclk;
         hold_q        <= hold_d;
         hold_full_q   <= hold_full_d;
         last_q        <= last_d;
         buf_q         <= buf_d;
         cnt_q         <= cnt_d;
         sdata_q       <= sdata_d;
         frame_start_q <= det;
         underrun_q    <= under;
         sync_err_q    <= short_frame;
      end
   end

   assign in_ready    = ~hold_full_q;
   assign sdata       = sdata_q;
   assign frame_start = frame_start_q;
   assign underrun    = underrun_q;
   assign sync_err    = sync_err_q;

endmodule
